// File: rtl/comparator_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_arbiter_pkg
//  Description : Shared widths, FSM state encoding and comparator result
//                codes for the shared-comparator arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package comparator_arbiter_pkg;

    localparam int CA_DATA_W = 16;
    localparam int CA_RES_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic signed [CA_RES_W-1:0] CMP_GT = 3'sd1;
    localparam logic signed [CA_RES_W-1:0] CMP_EQ = 3'sd0;
    localparam logic signed [CA_RES_W-1:0] CMP_LT = -3'sd2;

    // True when the comparator produced one of its three defined codes.
    function automatic logic cmp_legal(input logic signed [CA_RES_W-1:0] r);
        return (r == CMP_GT) || (r == CMP_EQ) || (r == CMP_LT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_arbiter_if
//  Description : Requester-side request/response bus of the arbiter. The
//                master modport is the requester collection, the slave
//                modport is the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface comparator_arbiter_if
    import comparator_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = CA_DATA_W
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*DATA_W-1:0]       req_a;
    logic [NUM_REQ*DATA_W-1:0]       req_b;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic signed [CA_RES_W-1:0]      rsp_result;
    logic                            rsp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/comparator_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Round-robin winner selection. Rotates the request vector so
//                the slot after last_i sits at bit 0, finds the first set
//                bit, then rotates the index back.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import comparator_arbiter_pkg::*;
#(
    parameter int N = 4
)(
    input  wire logic [N-1:0]         req_i,
    input  wire logic [$clog2(N)-1:0] last_i,
    output logic      [N-1:0]         grant_o,
    output logic      [$clog2(N)-1:0] idx_o,
    output logic                      any_o
);
    localparam int IDX_W = $clog2(N);

    int         start;
    int         first;
    int         idx;
    logic [N-1:0] rot;

    // Rotate, find-first from bit 0, rotate the winning index back.
    always_comb begin
        start = (int'(last_i) + 1) % N;
        rot   = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_i[(i + start) % N];
        end
        first = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = i;
        end
        idx     = (first + start) % N;
        any_o   = |req_i;
        idx_o   = IDX_W'(idx);
        grant_o = any_o ? (N'(1) << idx) : '0;
    end
endmodule
`default_nettype wire

// File: rtl/comparator_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_arbiter
//  Description : Shares one registered signed comparator among NUM_REQ
//                requesters. Round-robin grant in IDLE, operands registered
//                to the comparator, CMP_LATENCY wait cycles, capture of the
//                result, then a one-cycle response pulse to the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_arbiter
    import comparator_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = CA_DATA_W,
    parameter int CMP_LATENCY = 1
)(
    input  wire logic                       CLK,
    input  wire logic                       RST_N,
    comparator_arbiter_if.slave             bus,
    output logic                            busy,
    output logic [DATA_W-1:0]               CMP_A,
    output logic [DATA_W-1:0]               CMP_B,
    input  wire logic signed [CA_RES_W-1:0] CMP_DOUT
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 3;

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] WAIT    = ST_WAIT;
    localparam logic [1:0] CAPTURE = ST_CAPTURE;
    localparam logic [1:0] RESP    = ST_RESP;

    logic [1:0]                  state_q,  state_d;
    logic [CNT_W-1:0]            cnt_q,    cnt_d;
    logic [IDX_W-1:0]            grant_q,  grant_d;
    logic [IDX_W-1:0]            last_q,   last_d;
    logic [DATA_W-1:0]           cmp_a_q,  cmp_a_d;
    logic [DATA_W-1:0]           cmp_b_q,  cmp_b_d;
    logic signed [CA_RES_W-1:0]  res_q,    res_d;
    logic                        err_q,    err_d;

    logic [NUM_REQ-1:0]          pick_onehot;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_any;
    logic [NUM_REQ-1:0]          ready_vec;
    logic [NUM_REQ-1:0]          rsp_vec;

    rr_priority_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Next-state logic: grant in IDLE, count down the comparator latency,
    // capture the result, then pulse the response to the granted requester.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cmp_a_d   = cmp_a_q;
        cmp_b_d   = cmp_b_q;
        res_d     = res_q;
        err_d     = err_q;
        ready_vec = '0;
        rsp_vec   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ready_vec = pick_onehot;
                    cmp_a_d   = bus.req_a[int'(pick_idx)*DATA_W +: DATA_W];
                    cmp_b_d   = bus.req_b[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_d   = pick_idx;
                    last_d    = pick_idx;
                    cnt_d     = CNT_W'(CMP_LATENCY - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                res_d   = CMP_DOUT;
                err_d   = !cmp_legal(CMP_DOUT);
                state_d = RESP;
            end
            RESP: begin
                rsp_vec = NUM_REQ'(1) << grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A cycle spent in reset never accepts a request nor delivers a
        // response, so the handshake outputs are held low as well.
        if (!RST_N) begin
            ready_vec = '0;
            rsp_vec   = '0;
        end
    end

    // State, pointer and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.rsp_valid  = rsp_vec;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
    assign busy           = (state_q != IDLE);
    assign CMP_A          = cmp_a_q;
    assign CMP_B          = cmp_b_q;
endmodule
`default_nettype wire

// File: tb/tb_comparator_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_arbiter
//  Description : Self-checking bench. A transaction-level model predicts
//                grants, response timing and results; a behavioural
//                registered comparator sits on the CMP_* side. A second
//                instance exercises CMP_LATENCY=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_arbiter;
    import comparator_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L1 = 1;
    localparam int L3 = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    comparator_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus1 ();
    comparator_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus3 ();

    logic                busy1, busy3;
    logic [W-1:0]        cmpa1, cmpb1, cmpa3, cmpb3;
    logic signed [2:0]   dout1, dout3;
    logic                force_bad = 1'b0;
    logic signed [2:0]   pipe1;
    logic signed [2:0]   pipe3 [3];

    logic [N-1:0]        v1 = '0;
    logic [W-1:0]        a1 [N];
    logic [W-1:0]        b1 [N];
    logic [N-1:0]        v3 = '0;
    logic [N*W-1:0]      a3pk = '0;
    logic [N*W-1:0]      b3pk = '0;

    function automatic logic signed [2:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
        if ($signed(a) > $signed(b)) return 3'sd1;
        if (a == b) return 3'sd0;
        return -3'sd2;
    endfunction

    // Behavioural registered comparators: latency 1 and latency 3.
    always @(posedge CLK) begin
        pipe1    <= golden(cmpa1, cmpb1);
        pipe3[0] <= golden(cmpa3, cmpb3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout1 = force_bad ? 3'sd3 : pipe1;
    assign dout3 = pipe3[2];

    always_comb begin
        bus1.req_a = '0;
        bus1.req_b = '0;
        for (int i = 0; i < N; i++) begin
            bus1.req_a[i*W +: W] = a1[i];
            bus1.req_b[i*W +: W] = b1[i];
        end
    end
    assign bus1.req_valid = v1;
    assign bus3.req_valid = v3;
    assign bus3.req_a     = a3pk;
    assign bus3.req_b     = b3pk;

    comparator_arbiter #(.NUM_REQ(N), .DATA_W(W), .CMP_LATENCY(L1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus1), .busy(busy1),
        .CMP_A(cmpa1), .CMP_B(cmpb1), .CMP_DOUT(dout1)
    );

    comparator_arbiter #(.NUM_REQ(N), .DATA_W(W), .CMP_LATENCY(L3)) u_dut3 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus3), .busy(busy3),
        .CMP_A(cmpa3), .CMP_B(cmpb3), .CMP_DOUT(dout3)
    );

    // Next-cycle stimulus, applied just after the following rising edge.
    logic [N-1:0] nx_v = '0;
    logic [W-1:0] nx_a [N];
    logic [W-1:0] nx_b [N];
    logic         nx_rst   = 1'b1;
    logic         nx_force = 1'b0;
    logic [N-1:0] seen_ready = '0;

    // Transaction-level model of the latency-1 instance.
    bit                m_idle = 1'b1;
    int                m_t    = 0;
    int                m_g    = 0;
    int                m_last = N - 1;
    logic [W-1:0]      m_ca   = '0;
    logic [W-1:0]      m_cb   = '0;
    logic signed [2:0] m_res  = '0;
    logic              m_err  = 1'b0;
    logic signed [2:0] m_pend = '0;
    int                grants [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int off = 1; off <= N; off++) begin
            if (req[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic cyc();
        int           g;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        @(posedge CLK);
        #1;
        RST_N     = nx_rst;
        force_bad = nx_force;
        v1        = nx_v;
        for (int i = 0; i < N; i++) begin
            a1[i] = nx_a[i];
            b1[i] = nx_b[i];
        end
        @(negedge CLK);
        g       = -1;
        e_ready = '0;
        e_rsp   = '0;
        if (m_idle && RST_N && (|v1)) begin
            g       = rr_pick(v1, m_last);
            e_ready = N'(1) << g;
        end
        if (!m_idle && RST_N && (m_t == L1 + 2)) e_rsp = N'(1) << m_g;
        chk("req_ready",  32'(bus1.req_ready),  32'(e_ready));
        chk("rsp_valid",  32'(bus1.rsp_valid),  32'(e_rsp));
        chk("busy",       32'(busy1),           32'(!m_idle));
        chk("rsp_result", 32'(bus1.rsp_result), 32'(m_res));
        chk("rsp_err",    32'(bus1.rsp_err),    32'(m_err));
        chk("cmp_a",      32'(cmpa1),           32'(m_ca));
        chk("cmp_b",      32'(cmpb1),           32'(m_cb));
        seen_ready = bus1.req_ready;
        if (!RST_N) begin
            m_idle = 1'b1; m_t = 0; m_last = N - 1;
            m_ca = '0; m_cb = '0; m_res = '0; m_err = 1'b0;
        end else if (m_idle) begin
            if (g >= 0) begin
                m_idle = 1'b0; m_t = 1; m_g = g; m_last = g;
                m_ca   = a1[g]; m_cb = b1[g];
                m_pend = force_bad ? 3'sd3 : golden(a1[g], b1[g]);
                grants.push_back(g);
            end
        end else begin
            if (m_t == L1 + 1) begin
                m_res = m_pend;
                m_err = !(m_pend == 3'sd1 || m_pend == 3'sd0 || m_pend == -3'sd2);
            end
            m_t++;
            if (m_t > L1 + 2) m_idle = 1'b1;
        end
    endtask

    task automatic run(input int n, input bit drop);
        for (int k = 0; k < n; k++) begin
            cyc();
            if (drop) nx_v = nx_v & ~seen_ready;
        end
    endtask

    task automatic chk_grants(input string tag, input int exp [$]);
        chk({tag, "_count"}, 32'(grants.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < grants.size(); k++) begin
            chk(tag, 32'(grants[k]), 32'(exp[k]));
        end
    endtask

    task automatic l3_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic signed [2:0] exp_res, input string tag);
        int lat;
        lat = 999;
        @(posedge CLK);
        #1;
        v3 = 4'b0001;
        a3pk[W-1:0] = a;
        b3pk[W-1:0] = b;
        @(negedge CLK);
        chk({tag, "_ready"}, 32'(bus3.req_ready), 32'(4'b0001));
        @(posedge CLK);
        #1;
        v3 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (bus3.rsp_valid != '0) begin
                lat = c;
                chk({tag, "_rsp_valid"}, 32'(bus3.rsp_valid), 32'(4'b0001));
                chk({tag, "_result"}, 32'(bus3.rsp_result), 32'(exp_res));
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(5));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            nx_a[i] = '0; nx_b[i] = '0; a1[i] = '0; b1[i] = '0;
        end
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);

        // Reset state, then a single request from requester 1 (5 vs 4).
        run(2, 1'b1);
        grants.delete();
        nx_a[1] = 16'd5; nx_b[1] = 16'd4; nx_v = 4'b0010;
        run(6, 1'b1);
        chk_grants("t1_grant", '{1});
        chk("t1_result", 32'(bus1.rsp_result), 32'(CMP_GT));
        chk("t1_err", 32'(bus1.rsp_err), 32'(1'b0));

        // Fresh pointer, all four held with A=B=-2: order 0,1,2,3,0.
        nx_rst = 1'b0; run(1, 1'b1); nx_rst = 1'b1;
        grants.delete();
        for (int i = 0; i < N; i++) begin nx_a[i] = 16'hFFFE; nx_b[i] = 16'hFFFE; end
        nx_v = 4'b1111;
        run(20, 1'b0);
        nx_v = '0;
        run(2, 1'b1);
        chk_grants("t2_grant", '{0, 1, 2, 3, 0});
        chk("t2_result", 32'(bus1.rsp_result), 32'(CMP_EQ));

        // Fairness: after 2 is served, pending 0 and 3 go 3 then 0.
        grants.delete();
        nx_v = 4'b0100;
        run(5, 1'b1);
        nx_v = 4'b1001;
        run(10, 1'b1);
        chk_grants("t3_grant", '{2, 3, 0});

        // Negative operands on requester 0.
        nx_a[0] = -16'sd8; nx_b[0] = -16'sd4; nx_v = 4'b0001;
        run(6, 1'b1);
        chk("t4_lt", 32'(bus1.rsp_result), 32'(CMP_LT));
        nx_a[0] = -16'sd4; nx_b[0] = -16'sd8; nx_v = 4'b0001;
        run(6, 1'b1);
        chk("t4_gt", 32'(bus1.rsp_result), 32'(CMP_GT));

        // Reset during WAIT drops the response and restores the pointer.
        grants.delete();
        nx_a[0] = 16'd1; nx_b[0] = 16'd2; nx_v = 4'b0001;
        run(1, 1'b1);
        nx_rst = 1'b0;
        run(1, 1'b1);
        nx_rst = 1'b1;
        nx_a[3] = 16'd7; nx_b[3] = 16'd7; nx_v = 4'b1001;
        run(12, 1'b1);
        chk_grants("t5_grant", '{0, 0, 3});

        // Illegal comparator code flags rsp_err; the next legal result clears it.
        nx_force = 1'b1;
        nx_a[1] = 16'd0; nx_b[1] = 16'd0; nx_v = 4'b0010;
        run(5, 1'b1);
        chk("t6_err_set", 32'(bus1.rsp_err), 32'(1'b1));
        chk("t6_res_bad", 32'(bus1.rsp_result), 32'(3'sd3));
        nx_force = 1'b0;
        nx_a[1] = 16'd9; nx_b[1] = 16'd3; nx_v = 4'b0010;
        run(5, 1'b1);
        chk("t6_err_clr", 32'(bus1.rsp_err), 32'(1'b0));

        // Randomized traffic with occasional withdrawals and resets.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (nx_v[i] && seen_ready[i]) begin
                    nx_v[i] = 1'b0;
                end else if (!nx_v[i] && $urandom_range(0, 3) == 0) begin
                    nx_v[i] = 1'b1;
                    nx_a[i] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 7) - 4);
                    nx_b[i] = ($urandom_range(0, 3) == 0) ? nx_a[i] : W'($urandom);
                end else if (nx_v[i] && $urandom_range(0, 49) == 0) begin
                    nx_v[i] = 1'b0;
                end
            end
            nx_rst = ($urandom_range(0, 150) != 0);
            cyc();
        end
        nx_rst = 1'b1;
        nx_v   = '0;
        run(8, 1'b1);

        // Latency-3 instance: response arrives five cycles after accept.
        l3_txn(-16'sd8, -16'sd4, CMP_LT, "l3_lt");
        l3_txn(-16'sd4, -16'sd8, CMP_GT, "l3_gt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/comparator_arbiter.md
Name: comparator_arbiter

Overview:
- Shares one registered 16-bit signed comparator among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Drives the comparator operands, waits CMP_LATENCY cycles, then returns the 3-bit signed result to the granted requester.
- Result encoding is the comparator's: +1 for A>B, 0 for A==B, -2 for A<B.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand width (signed two's complement).
- CMP_LATENCY, 1, clock edges from operand change to valid comparator dout (1..7).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*DATA_W  packed A operands; requester i uses slice [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed B operands, same packing.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot one-cycle response pulse.
- rsp_result  out  3 signed  comparison result; valid while any rsp_valid bit is high.
- rsp_err  out  1  high with rsp_valid when CMP_DOUT is not in {1, 0, -2}.
- busy  out  1  high in every state except IDLE.
- CMP_A  out  DATA_W  registered operand A to comparator.
- CMP_B  out  DATA_W  registered operand B to comparator.
- CMP_DOUT  in  3 signed  comparator result.

Behaviour:
- Interface: one clock (CLK); reset RST_N is synchronous and active-low.
- Reset values: all outputs 0, including CMP_A, CMP_B and rsp_result. State = IDLE. Wait counter = 0. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has highest priority first.
- FSM IDLE -> WAIT -> CAPTURE -> RESP -> IDLE.
  - IDLE, no request: stay in IDLE.
  - IDLE, any req_valid: winner g = first set bit searching from (last_grant+1) mod NUM_REQ upward, with wrap-around.
    - req_ready[g] = 1 combinationally in this cycle only.
    - At the edge: CMP_A/CMP_B <= slices g, last_grant <= g, grant register <= g, counter <= CMP_LATENCY-1, go to WAIT.
  - WAIT: counter decrements each cycle; leave for CAPTURE when counter == 0. WAIT lasts exactly CMP_LATENCY cycles.
  - CAPTURE: CMP_DOUT is valid this cycle. At the edge, rsp_result <= CMP_DOUT and rsp_err <= (CMP_DOUT not in {1, 0, -2}). Go to RESP.
  - RESP: rsp_valid[grant] = 1 for exactly one cycle; go to IDLE.
- Timing at CMP_LATENCY=1:
  - Accept in cycle 0; rsp_valid in cycle 3; next accept possible in cycle 4.
  - Throughput is one compare per CMP_LATENCY+3 cycles.
- CMP_A/CMP_B hold their values until the next accept; they do not return to 0 after a response.
- rsp_result and rsp_err hold their last values between responses. Consumers sample them only on rsp_valid.
- Handshake rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Deasserting req_valid before acceptance withdraws the request, with no side effect.
  - req_ready is never asserted outside IDLE.
  - A requester may re-request in the cycle after its rsp_valid.
- Simultaneous requests: exactly one grant per IDLE visit. A requester that keeps req_valid asserted is served within NUM_REQ transactions.
- Reset mid-operation (any state): return to IDLE with all outputs cleared. The in-flight response is dropped and no rsp_valid is emitted. The pointer resets to NUM_REQ-1.

Decomposition:
- Shared package:
  - State enum (IDLE, WAIT, CAPTURE, RESP).
  - Result constants CMP_GT = 3'sd1, CMP_EQ = 3'sd0, CMP_LT = -3'sd2.
  - Default widths DATA_W and result width 3.
- One sub-module, rr_priority_pick:
  - Inputs: request vector, last_grant.
  - Outputs: one-hot winner plus its index, using rotate / find-first / rotate-back.
- The FSM, counter and operand registers stay in the top module.
- Bench instantiates comparator_arbiter with the real comparator as the CMP_* partner.

Test Plan:
- Single request, CMP_LATENCY=1: req 1 with A=5, B=4 -> req_ready[1] in cycle 0; rsp_valid = 4'b0010 in cycle 3; rsp_result = 1; rsp_err = 0.
- All four requests held, A=B=-2 for all -> grants in order 0,1,2,3 (one accept every 4 cycles), each rsp_result = 0; a fifth round grants 0 again.
- Fairness: req 2 granted, then reqs 0 and 3 both pending -> next grant is 3, then 0.
- Negative operands: req 0 with A=-8, B=-4 -> rsp_result = -2; with A=-4, B=-8 -> 1. Repeat with CMP_LATENCY=3: rsp_valid in cycle 5.
- Reset mid-WAIT: RST_N=0 for one cycle during WAIT -> no rsp_valid; all outputs 0 the next cycle; a held req 3 is then accepted only after req 0's pending request (pointer reset).
- Stub comparator forcing CMP_DOUT = 3 -> rsp_err = 1 with rsp_valid; the next legal result clears rsp_err.
